// File: rtl/lcd_ctrl.sv
// HD44780-style LCD controller: queues MMIO writes in a FIFO and replays
// them on the parallel bus with setup/enable/hold/execute timing.
module lcd_ctrl #(
    parameter int T_SETUP    = 2,
    parameter int T_EN       = 12,
    parameter int T_HOLD     = 2,
    parameter int T_EXEC     = 2000,
    parameter int T_CLEAR    = 82000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lcd_word,
    input  logic        i_lcd_vld,
    output logic        o_lcd_busy,
    output logic        o_lcd_full,
    output logic        o_lcd_ovf,
    output logic        o_lcd_on,
    output logic        o_lcd_blon,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TM0  = (T_SETUP > T_EN) ? T_SETUP : T_EN;
    localparam int TM1  = (TM0 > T_HOLD) ? TM0 : T_HOLD;
    localparam int TM2  = (TM1 > T_EXEC) ? TM1 : T_EXEC;
    localparam int TMAX = (TM2 > T_CLEAR) ? TM2 : T_CLEAR;
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wp;
    logic [AW:0]   rp;
    logic [AW:0]   wp_nx;
    logic [AW:0]   rp_nx;
    logic          empty;
    logic          full;
    logic          full_nx;
    logic          push;
    logic          pop;
    logic          nx_idle;
    logic          clr;
    logic          unused_bits;

    assign unused_bits = ^{i_lcd_word[29:10], i_lcd_word[8]};

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign push    = i_lcd_vld && !full;
    assign pop     = (state == S_IDLE) && !empty;
    assign wp_nx   = push ? wp + (AW+1)'(1) : wp;
    assign rp_nx   = pop ? rp + (AW+1)'(1) : rp;
    assign full_nx = (wp_nx[AW] != rp_nx[AW]) &&
                     (wp_nx[AW-1:0] == rp_nx[AW-1:0]);
    assign nx_idle = ((state == S_IDLE) && !pop) ||
                     ((state == S_WAIT) && (cnt == '0));

    // clear/home instructions need the long execution wait
    assign clr = !o_lcd_rs && (o_lcd_data[7:2] == 6'd0) &&
                 (o_lcd_data[1:0] != 2'd0);

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wp[AW-1:0]] <= {i_lcd_word[9], i_lcd_word[7:0]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            wp         <= '0;
            rp         <= '0;
            o_lcd_busy <= 1'b0;
            o_lcd_full <= 1'b0;
            o_lcd_ovf  <= 1'b0;
            o_lcd_on   <= 1'b0;
            o_lcd_blon <= 1'b0;
            o_lcd_en   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_rw   <= 1'b0;
            o_lcd_data <= 8'h00;
        end else begin
            wp         <= wp_nx;
            rp         <= rp_nx;
            o_lcd_full <= full_nx;
            o_lcd_busy <= !nx_idle || (wp_nx != rp_nx);
            o_lcd_rw   <= 1'b0;
            if (i_lcd_vld) begin
                o_lcd_on   <= i_lcd_word[31];
                o_lcd_blon <= i_lcd_word[30];
                if (full) o_lcd_ovf <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        {o_lcd_rs, o_lcd_data} <= mem[rp[AW-1:0]];
                        cnt   <= CW'(T_SETUP - 1);
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        o_lcd_en <= 1'b1;
                        cnt      <= CW'(T_EN - 1);
                        state    <= S_PULSE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt == '0) begin
                        o_lcd_en <= 1'b0;
                        cnt      <= CW'(T_HOLD - 1);
                        state    <= S_HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= clr ? CW'(T_CLEAR - 1) : CW'(T_EXEC - 1);
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters.
module tb_lcd_ctrl;
    logic        clk;
    logic        rst_n;
    logic [31:0] word;
    logic        vld;
    logic        busy, full, ovf, on, blon, en, rs, rw;
    logic [7:0]  data;

    int n_chk;
    int n_fail;
    logic [7:0] seen[$];
    logic pe;

    lcd_ctrl #(
        .T_SETUP(2), .T_EN(3), .T_HOLD(2),
        .T_EXEC(5), .T_CLEAR(20), .FIFO_DEPTH(4)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_lcd_word(word), .i_lcd_vld(vld),
        .o_lcd_busy(busy), .o_lcd_full(full), .o_lcd_ovf(ovf),
        .o_lcd_on(on), .o_lcd_blon(blon), .o_lcd_en(en),
        .o_lcd_rs(rs), .o_lcd_rw(rw), .o_lcd_data(data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial pe = 1'b0;
    always @(negedge clk) begin
        if (en === 1'b1 && pe !== 1'b1) seen.push_back(data);
        pe = en;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", (k < 500), 1);
    endtask

    // one command from idle; cycle 0 is the strobe cycle
    task automatic run_cmd(input logic [31:0] w, input logic exp_rs,
                           input logic [7:0] exp_d, input int wt);
        @(negedge clk);
        word = w;
        vld  = 1'b1;
        for (int c = 1; c <= 10 + wt; c++) begin
            @(negedge clk);
            if (c == 1) begin
                vld = 1'b0;
                check("cmd_on", on, w[31]);
                check("cmd_blon", blon, w[30]);
            end
            if (c >= 2) begin
                check("cmd_rs", rs, exp_rs);
                check("cmd_data", data, exp_d);
            end
            check("cmd_en", en, (c >= 4 && c <= 6));
            check("cmd_busy", busy, (c < 9 + wt));
            check("cmd_rw", rw, 0);
        end
    endtask

    task automatic burst(input int n, input logic [7:0] base);
        seen.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            word = 32'h0000_0200 | 32'(base + 8'(i));
            vld  = 1'b1;
        end
        @(negedge clk);
        vld = 1'b0;
        wait_idle();
        check("burst_cnt", seen.size(), n);
        for (int i = 0; i < n && i < seen.size(); i++)
            check("burst_ord", seen[i], base + 8'(i));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        vld    = 1'b0;
        word   = '0;
        repeat (3) @(negedge clk);
        check("rst_outs", {busy, full, ovf, on, blon, en, rs, rw, data}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(32'h0000_0241, 1'b1, 8'h41, 5);

        // clear command followed by a queued data write
        @(negedge clk);
        word = 32'hC000_0001;
        vld  = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("clr_on", on, 1);
                check("clr_blon", blon, 1);
                word = 32'hC000_0242;
            end
            if (c == 2) vld = 1'b0;
            if (c >= 2) begin
                check("clr_data", data, (c < 30) ? 8'h01 : 8'h42);
                check("clr_rs", rs, (c < 30) ? 1'b0 : 1'b1);
            end
            check("clr_busy", busy, 1);
        end
        wait_idle();

        run_cmd(32'h8000_0300, 1'b1, 8'h00, 5);

        // overflow burst
        seen.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 4) check("ovf_full4", full, 0);
            if (i == 5) begin
                check("ovf_full5", full, 1);
                check("ovf_ovf5", ovf, 0);
            end
            word = 32'h0000_0210 + 32'(i);
            vld  = 1'b1;
        end
        @(negedge clk);
        vld = 1'b0;
        check("ovf_ovf6", ovf, 1);
        check("ovf_full6", full, 1);
        wait_idle();
        check("ovf_cnt", seen.size(), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++)
            check("ovf_ord", seen[i], 8'h10 + 8'(i));
        check("ovf_sticky", ovf, 1);
        check("ovf_full_end", full, 0);

        // strobe during WAIT of a previous command
        @(negedge clk);
        word = 32'h0000_0220;
        vld  = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            if (c == 1) vld = 1'b0;
            if (c >= 2) check("wait_data", data, (c < 15) ? 8'h20 : 8'h21);
            check("wait_en", en, (c >= 4 && c <= 6) || (c >= 17 && c <= 19));
            check("wait_busy", busy, (c < 27));
            if (c == 10) begin
                word = 32'h0000_0221;
                vld  = 1'b1;
            end
            if (c == 11) vld = 1'b0;
        end
        wait_idle();

        burst(4, 8'h30);
        burst(4, 8'h34);

        // reset while enable is high
        @(negedge clk);
        word = 32'hC000_0255;
        vld  = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) word = 32'hC000_0266;
            if (c == 2) vld = 1'b0;
            if (c == 5) begin
                check("mid_en", en, 1);
                rst_n = 1'b0;
            end
            if (c == 6) begin
                check("mid_rst", {en, rs, data, on, blon, ovf, busy, full}, 0);
                rst_n = 1'b1;
            end
            if (c >= 7) check("mid_empty", {busy, en, full}, 0);
        end

        run_cmd(32'h0000_0241, 1'b1, 8'h41, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
